tdm_demux14: RTL
================

Name: tdm_demux14

Overview:
- Sequential 1-to-4 time-division demultiplexer: the receive-side counterpart of the 4:1 selector.
- Takes an interleaved stream of beats (lane 0, 1, 2, 3, 0, ...) and steers each beat into its lane's shadow register.
- Once all four lanes of a frame are captured, publishes them atomically as one 4-lane word.
- Sits between a serialised link or selector output and parallel consumers (LEDs, display drivers) on the Mimas V2 board.

Parameters:
- WIDTH, 1, bits per lane / per input beat.
- CNT_W, 8, width of the completed-frame counter.

Ports:
- clk  input  1  system clock, all logic rising-edge.
- rst  input  1  asynchronous, active-high reset.
- d  input  WIDTH  beat data.
- d_valid  input  1  beat qualifier; d and sync are sampled only when high.
- sync  input  1  marks the current beat as lane 0 (frame start).
- o  output  4*WIDTH  published frame; lane k occupies bits [k*WIDTH +: WIDTH].
- o_valid  output  1  one-cycle pulse when o is updated.
- frame_err  output  1  one-cycle pulse on a sync arriving mid-frame.
- locked  output  1  high once frame alignment is acquired.
- chan  output  2  lane index the next valid beat will be written to.
- frame_cnt  output  CNT_W  completed frames, wraps modulo 2^CNT_W.

Behaviour:
- Reset (asynchronous, active-high): state=HUNT, chan=0, shadow lanes 0..2=0, o=0, o_valid=0, frame_err=0, locked=0, frame_cnt=0. Asserting rst mid-frame discards the partial frame immediately.
- States: HUNT and RUN. locked=1 exactly when state=RUN (registered).
- HUNT:
  - Valid beats with sync=0 are discarded; chan stays 0.
  - A valid beat with sync=1 writes shadow lane 0, sets chan=1, and moves to RUN.
- RUN, valid beat:
  - Data is written to lane[chan], then chan increments.
  - sync=0 at chan=0 is accepted; sync is needed only to acquire lock.
  - sync=1 at chan=0 is a normal frame start.
- RUN, valid beat with sync=1 at chan!=0 (realign):
  - Pulse frame_err next cycle.
  - Discard the partial frame; shadow lanes are not cleared but are overwritten by the new frame.
  - Write the beat to lane 0, set chan=1, stay in RUN.
  - No o_valid pulse for the discarded frame.
- Lane-3 beat (chan=3, valid, sync=0):
  - Next cycle: o={d, shadow2, shadow1, shadow0}, o_valid=1 for exactly one cycle, chan=0, frame_cnt+1.
  - Latency: 1 clk from the lane-3 sample to o/o_valid.
- d_valid=0: all state holds. Gaps of any length between beats are legal.
- o holds its last value between frames; only a lane-3 completion updates it.
- frame_cnt wraps from 2^CNT_W-1 to 0 with no flag.
- Back-to-back frames with no gaps yield o_valid every 4th cycle. Throughput: 1 beat/clk.
- There is no output backpressure; the consumer must sample o on the o_valid pulse.

Decomposition:
- Package tdm_pkg holds:
  - LANES=4
  - IDX_W=2
  - state encoding HUNT=1'b0, RUN=1'b1
  - lane-slice helper constants
- No sub-module is required. The lane counter and state register stay in a single module.

Test Plan:
- Reset, then sync+beats d=1,0,1,1 (WIDTH=1) on 4 consecutive cycles -> o=4'b1101 and o_valid high for one cycle, 1 clk after the 4th beat; frame_cnt=1, locked=1.
- Before any sync, beats 1,1,1 with sync=0 -> o=0, no o_valid, locked=0, chan=0. Then sync+1,0,0,0 -> o=4'b0001.
- In RUN after beats 1,1 (chan=2), a beat with sync=1, d=0 -> frame_err pulse, chan=1. Following 1,1,1 -> o=4'b1110 and a single o_valid.
- Frame 1,0,0,1 with d_valid low for 3 cycles between each beat -> o=4'b1001 once; o unchanged during gaps; chan steps 0→1→2→3→0.
- Assert rst after 2 beats of a frame -> all outputs 0 asynchronously (before the next clk edge). After release, a full sync frame 0,1,1,0 -> o=4'b0110.
- CNT_W=2: 5 back-to-back frames -> o_valid on cycles 4,8,12,16,20 after the first beat; frame_cnt sequence 1,2,3,0,1.

Source files
------------

// File: rtl/tdm_pkg.sv
// Shared constants for the 1-to-4 TDM demultiplexer: lane geometry and FSM encoding.
package tdm_pkg;

  localparam int unsigned LANES        = 4;
  localparam int unsigned IDX_W        = 2;
  localparam int unsigned SHADOW_LANES = LANES - 1;

  localparam logic [0:0] HUNT = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  localparam logic [IDX_W-1:0] LANE_FIRST = 2'd0;
  localparam logic [IDX_W-1:0] LANE_LAST  = 2'd3;

  // Bit offset of lane k inside a packed multi-lane word.
  function automatic int unsigned lane_lo(input int unsigned k, input int unsigned width);
    return k * width;
  endfunction

endpackage

// File: rtl/tdm_demux14.sv
// Sequential 1-to-4 TDM demultiplexer: steers interleaved beats into lane shadows and
// publishes each completed frame atomically with a one-cycle o_valid pulse.
module tdm_demux14
  import tdm_pkg::*;
#(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [WIDTH-1:0]       d,
  input  logic                   d_valid,
  input  logic                   sync,
  output logic [LANES*WIDTH-1:0] o,
  output logic                   o_valid,
  output logic                   frame_err,
  output logic                   locked,
  output logic [IDX_W-1:0]       chan,
  output logic [CNT_W-1:0]       frame_cnt
);

  logic [0:0]                      state, state_nxt;
  logic [SHADOW_LANES*WIDTH-1:0]   shadow, shadow_nxt;
  logic [IDX_W-1:0]                chan_nxt;
  logic [LANES*WIDTH-1:0]          o_nxt;
  logic                            o_valid_nxt;
  logic                            frame_err_nxt;
  logic [CNT_W-1:0]                cnt_nxt;

  // State and output registers; reset drops any partial frame immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= HUNT;
      shadow    <= '0;
      chan      <= LANE_FIRST;
      o         <= '0;
      o_valid   <= 1'b0;
      frame_err <= 1'b0;
      frame_cnt <= '0;
    end else begin
      state     <= state_nxt;
      shadow    <= shadow_nxt;
      chan      <= chan_nxt;
      o         <= o_nxt;
      o_valid   <= o_valid_nxt;
      frame_err <= frame_err_nxt;
      frame_cnt <= cnt_nxt;
    end
  end

  // Next-state and output logic; pulses default low, everything else holds.
  always_comb begin
    state_nxt     = state;
    shadow_nxt    = shadow;
    chan_nxt      = chan;
    o_nxt         = o;
    o_valid_nxt   = 1'b0;
    frame_err_nxt = 1'b0;
    cnt_nxt       = frame_cnt;

    if (d_valid) begin
      if (state == HUNT) begin
        if (sync) begin
          shadow_nxt[lane_lo(0, WIDTH) +: WIDTH] = d;
          chan_nxt  = IDX_W'(1);
          state_nxt = RUN;
        end
      end else if (sync && (chan != LANE_FIRST)) begin
        // Realign: stale shadow lanes are simply overwritten by the new frame.
        frame_err_nxt = 1'b1;
        shadow_nxt[lane_lo(0, WIDTH) +: WIDTH] = d;
        chan_nxt = IDX_W'(1);
      end else if (chan == LANE_LAST) begin
        o_nxt       = {d, shadow};
        o_valid_nxt = 1'b1;
        chan_nxt    = LANE_FIRST;
        cnt_nxt     = frame_cnt + CNT_W'(1);
      end else begin
        for (int unsigned k = 0; k < SHADOW_LANES; k++) begin
          if (chan == IDX_W'(k)) begin
            shadow_nxt[lane_lo(k, WIDTH) +: WIDTH] = d;
          end
        end
        chan_nxt = chan + IDX_W'(1);
      end
    end
  end

  assign locked = (state == RUN);

endmodule
